bilin_scale_ctrl: RTL and testbench

Horizontal scaling sequencer for the bilinear interpolation datapath (one bilin_insert instance plus a source line buffer).
- Per output pixel, steps an 8.8 fixed-point DDA across the source line.
- Issues two line-buffer read addresses (left/right neighbour) and the aligned 8-bit fractional weight (Kremain).
- Produces an output-valid/last strobe aligned with the datapath's Dout.
- Handles frame start, per-line handshake with the line-buffer writer, edge clamping, and drain.

---
 rtl/bilin_scale_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_bilin_scale_ctrl.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bilin_scale_ctrl.sv
// Horizontal scaling sequencer for the bilinear interpolator.
// Steps an 8.8 DDA per output pixel and aligns weight/valid to the datapath.
module bilin_scale_ctrl #(
    parameter int AW     = 11,
    parameter int RD_LAT = 1,
    parameter int DP_LAT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] cfg_src_w,
    input  logic [AW-1:0] cfg_dst_w,
    input  logic [AW-1:0] cfg_lines,
    input  logic [15:0]   cfg_step,
    input  logic          line_rdy,
    output logic          line_done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr1,
    output logic [AW-1:0] rd_addr2,
    output logic [7:0]    kremain,
    output logic          out_valid,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);
    localparam int VL  = RD_LAT + DP_LAT;
    localparam int ACW = AW + 9;

    typedef enum logic [2:0] {
        IDLE, WAIT_LINE, RUN, DRAIN, FIN
    } state_t;

    state_t state, state_nx;

    logic [AW-1:0]  src_w, dst_w, lines;
    logic [15:0]    step;
    logic [AW-1:0]  x, line_cnt;
    logic [ACW-1:0] acc;
    logic           drained;
    logic           cfg_ok;
    logic [AW-1:0]  last_i;
    logic [AW:0]    ipart;
    logic [AW+1:0]  ipart_p1;
    logic           clamp;
    logic [7:0]     k;
    logic           is_last;

    logic [7:0] k_pipe [RD_LAT];
    logic       v_pipe [VL];
    logic       l_pipe [VL];

    assign cfg_ok = (cfg_src_w >= AW'(2)) && (cfg_dst_w != '0) &&
                    (cfg_lines != '0);

    // Integer part keeps the accumulator top bit so overshoot still clamps
    assign last_i   = src_w - AW'(1);
    assign ipart    = acc[ACW-1:8];
    assign ipart_p1 = {1'b0, ipart} + (AW+2)'(1);
    assign clamp    = ipart >= {1'b0, last_i};

    assign busy      = (state != IDLE);
    assign kremain   = k_pipe[RD_LAT-1];
    assign out_valid = v_pipe[VL-1];
    assign out_last  = l_pipe[VL-1];

    always_comb begin
        state_nx  = state;
        rd_en     = 1'b0;
        rd_addr1  = '0;
        rd_addr2  = '0;
        k         = '0;
        is_last   = 1'b0;
        line_done = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && cfg_ok) state_nx = WAIT_LINE;
            end
            WAIT_LINE: begin
                if (line_rdy) state_nx = RUN;
            end
            RUN: begin
                rd_en    = 1'b1;
                rd_addr1 = clamp ? last_i : ipart[AW-1:0];
                rd_addr2 = (ipart_p1 >= {2'b00, last_i}) ?
                           last_i : ipart_p1[AW-1:0];
                k        = clamp ? 8'd0 : acc[7:0];
                is_last  = (x == dst_w - AW'(1));
                if (is_last) state_nx = DRAIN;
            end
            DRAIN: begin
                if (drained) begin
                    line_done = 1'b1;
                    state_nx  = (line_cnt + AW'(1) == lines) ?
                                FIN : WAIT_LINE;
                end
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (abort) begin
            state_nx  = IDLE;
            line_done = 1'b0;
            done      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            src_w    <= '0;
            dst_w    <= '0;
            lines    <= '0;
            step     <= '0;
            acc      <= '0;
            x        <= '0;
            line_cnt <= '0;
            drained  <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state <= state_nx;
            if (abort) begin
                drained <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && cfg_ok) begin
                            src_w    <= cfg_src_w;
                            dst_w    <= cfg_dst_w;
                            lines    <= cfg_lines;
                            step     <= cfg_step;
                            line_cnt <= '0;
                            cfg_err  <= 1'b0;
                        end else if (start) begin
                            cfg_err <= 1'b1;
                        end
                    end
                    WAIT_LINE: begin
                        acc     <= '0;
                        x       <= '0;
                        drained <= 1'b0;
                    end
                    RUN: begin
                        acc <= acc + ACW'(step);
                        x   <= x + AW'(1);
                    end
                    DRAIN: begin
                        if (out_last) drained <= 1'b1;
                        if (drained) begin
                            drained  <= 1'b0;
                            line_cnt <= line_cnt + AW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Weight and valid/last delay lines; abort empties them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < RD_LAT; n++) k_pipe[n] <= '0;
            for (int n = 0; n < VL; n++) begin
                v_pipe[n] <= 1'b0;
                l_pipe[n] <= 1'b0;
            end
        end else if (abort) begin
            for (int n = 0; n < RD_LAT; n++) k_pipe[n] <= '0;
            for (int n = 0; n < VL; n++) begin
                v_pipe[n] <= 1'b0;
                l_pipe[n] <= 1'b0;
            end
        end else begin
            k_pipe[0] <= k;
            v_pipe[0] <= rd_en;
            l_pipe[0] <= is_last;
            for (int n = 1; n < RD_LAT; n++) k_pipe[n] <= k_pipe[n-1];
            for (int n = 1; n < VL; n++) begin
                v_pipe[n] <= v_pipe[n-1];
                l_pipe[n] <= l_pipe[n-1];
            end
        end
    end

endmodule

// File: tb/tb_bilin_scale_ctrl.sv
// Bench for bilin_scale_ctrl with a line-buffer and interpolator model.
// Expected reads/outputs are queued at stimulus time and popped by a monitor.
module tb_bilin_scale_ctrl;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] cfg_src_w = '0;
    logic [AW-1:0] cfg_dst_w = '0;
    logic [AW-1:0] cfg_lines = '0;
    logic [15:0]   cfg_step = '0;
    logic          line_rdy = 1'b0;
    logic          line_done, rd_en, out_valid, out_last;
    logic          busy, done, cfg_err;
    logic [AW-1:0] rd_addr1, rd_addr2;
    logic [7:0]    kremain;

    bilin_scale_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_src_w(cfg_src_w), .cfg_dst_w(cfg_dst_w),
        .cfg_lines(cfg_lines), .cfg_step(cfg_step),
        .line_rdy(line_rdy), .line_done(line_done),
        .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .kremain(kremain), .out_valid(out_valid), .out_last(out_last),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a1; int a2; int k; bit last; int dout;
    } exp_t;

    exp_t exp_q[$];
    exp_t out_q[$];
    int   got_dout[$];
    int   asserts = 0;
    int   fails = 0;
    int   cyc = 0;
    int   n_rd, n_valid, n_ld, n_done;
    int   t_first_rd, t_first_valid, t_last, t_ld, t_done;

    // Line buffer (1-cycle read) and 3-stage interpolator
    logic [7:0] pix [2048];
    int din1, din2, dp0, dp1, dp2;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) begin
            din1 <= int'(pix[rd_addr1]);
            din2 <= int'(pix[rd_addr2]);
        end
        dp0 <= din1 + (((din2 - din1) * int'(kremain)) >>> 8);
        dp1 <= dp0;
        dp2 <= dp1;
    end

    function automatic int model_dout(int a1, int a2, int k);
        int p1, p2;
        p1 = int'(pix[a1]);
        p2 = int'(pix[a2]);
        return p1 + (((p2 - p1) * k) >>> 8);
    endfunction

    bit   k_pend = 0;
    int   k_exp = 0;
    exp_t me;

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            out_q.delete();
            k_pend = 0;
        end else begin
            if (k_pend) begin
                asserts++;
                if (kremain !== 8'(k_exp)) begin
                    fails++;
                    $display("FAIL kremain got %0d exp %0d", kremain, k_exp);
                end
            end
            k_pend = 0;
            if (rd_en) begin
                n_rd++;
                if (t_first_rd < 0) t_first_rd = cyc;
                asserts++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rd_extra got addr %0d exp none", rd_addr1);
                end else begin
                    me = exp_q.pop_front();
                    if (rd_addr1 !== AW'(me.a1) || rd_addr2 !== AW'(me.a2)) begin
                        fails++;
                        $display("FAIL rd_addr got %0d/%0d exp %0d/%0d",
                                 rd_addr1, rd_addr2, me.a1, me.a2);
                    end
                    k_pend = 1;
                    k_exp = me.k;
                    out_q.push_back(me);
                end
            end
            if (out_valid) begin
                n_valid++;
                got_dout.push_back(dp2);
                if (t_first_valid < 0) t_first_valid = cyc;
                if (out_last) t_last = cyc;
                asserts++;
                if (out_q.size() == 0) begin
                    fails++;
                    $display("FAIL out_extra got dout %0d exp none", dp2);
                end else begin
                    me = out_q.pop_front();
                    if (out_last !== me.last || dp2 !== me.dout) begin
                        fails++;
                        $display("FAIL dout got %0d last %0b exp %0d last %0b",
                                 dp2, out_last, me.dout, me.last);
                    end
                end
            end
            if (line_done) begin n_ld++; t_ld = cyc; end
            if (done) begin n_done++; t_done = cyc; end
            if (abort) begin
                exp_q.delete();
                out_q.delete();
                k_pend = 0;
            end
        end
    end

    task automatic clear_stats();
        n_rd = 0; n_valid = 0; n_ld = 0; n_done = 0;
        t_first_rd = -1; t_first_valid = -1;
        t_last = -1; t_ld = -1; t_done = -1;
        got_dout.delete();
    endtask

    task automatic fill_pix();
        for (int i = 0; i < 2048; i++) pix[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic push_exp(int a1, int a2, int k, bit last);
        exp_t e;
        e.a1 = a1; e.a2 = a2; e.k = k; e.last = last;
        e.dout = model_dout(a1, a2, k);
        exp_q.push_back(e);
    endtask

    task automatic push_model(int src, int dst, int stp);
        int acc, i, a1, a2, k;
        for (int x = 0; x < dst; x++) begin
            acc = x * stp;
            i = acc >> 8;
            a1 = (i < src - 1) ? i : src - 1;
            a2 = (i + 1 < src - 1) ? i + 1 : src - 1;
            k = (i >= src - 1) ? 0 : (acc & 255);
            push_exp(a1, a2, k, x == dst - 1);
        end
    endtask

    task automatic do_start(int src, int dst, int ln, int stp);
        @(posedge clk); #1;
        cfg_src_w = AW'(src);
        cfg_dst_w = AW'(dst);
        cfg_lines = AW'(ln);
        cfg_step  = 16'(stp);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_pulse(bit want_done, int max, output bit ok);
        ok = 0;
        for (int c = 0; c < max; c++) begin
            @(negedge clk);
            if (want_done ? done : line_done) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        asserts++;
        if ({rd_en, rd_addr1, rd_addr2, kremain} !== '0) begin
            fails++;
            $display("FAIL reset_rd got %0b %0d %0d %0d exp 0",
                     rd_en, rd_addr1, rd_addr2, kremain);
        end
        asserts++;
        if ({out_valid, out_last, line_done, done} !== 4'b0) begin
            fails++;
            $display("FAIL reset_strobes got %b exp 0000",
                     {out_valid, out_last, line_done, done});
        end
        asserts++;
        if ({busy, cfg_err} !== 2'b00) begin
            fails++;
            $display("FAIL reset_status got %b exp 00", {busy, cfg_err});
        end
        rst = 1'b1;
    endtask

    task automatic test_upscale();
        int a1[7] = '{0, 0, 1, 1, 2, 2, 3};
        int a2[7] = '{1, 1, 2, 2, 3, 3, 3};
        int kk[7] = '{0, 128, 0, 128, 0, 128, 0};
        bit ok;
        fill_pix();
        clear_stats();
        for (int x = 0; x < 7; x++) push_exp(a1[x], a2[x], kk[x], x == 6);
        line_rdy = 1'b1;
        do_start(4, 7, 1, 'h80);
        wait_pulse(1, 100, ok);
        asserts++;
        if (!ok) begin fails++; $display("FAIL up_done got none exp pulse"); end
        @(negedge clk);
        asserts++;
        if (n_valid !== 7) begin
            fails++; $display("FAIL up_count got %0d exp 7", n_valid);
        end
        asserts++;
        if (t_first_valid - t_first_rd !== 4) begin
            fails++;
            $display("FAIL up_latency got %0d exp 4", t_first_valid - t_first_rd);
        end
        asserts++;
        if (t_ld - t_last !== 1) begin
            fails++; $display("FAIL up_line_done got %0d exp 1", t_ld - t_last);
        end
        asserts++;
        if (t_done - t_ld !== 1) begin
            fails++; $display("FAIL up_done_gap got %0d exp 1", t_done - t_ld);
        end
        asserts++;
        if (busy !== 1'b0 || exp_q.size() + out_q.size() !== 0) begin
            fails++;
            $display("FAIL up_idle got busy %0b left %0d exp 0 0",
                     busy, exp_q.size() + out_q.size());
        end
    endtask

    task automatic test_downscale();
        int a1[3] = '{0, 2, 5};
        int a2[3] = '{1, 3, 6};
        int kk[3] = '{'h00, 'hAB, 'h56};
        bit ok;
        fill_pix();
        clear_stats();
        for (int x = 0; x < 3; x++) push_exp(a1[x], a2[x], kk[x], x == 2);
        do_start(8, 3, 1, 'h2AB);
        wait_pulse(1, 100, ok);
        asserts++;
        if (!ok) begin fails++; $display("FAIL down_done got none exp pulse"); end
        @(negedge clk);
        asserts++;
        if (n_valid !== 3) begin
            fails++; $display("FAIL down_count got %0d exp 3", n_valid);
        end
    endtask

    task automatic test_clamp();
        int want[4] = '{10, 200, 200, 200};
        bit ok;
        pix[0] = 8'd10;
        pix[1] = 8'd200;
        clear_stats();
        push_model(2, 4, 'h100);
        do_start(2, 4, 1, 'h100);
        wait_pulse(1, 100, ok);
        asserts++;
        if (!ok) begin fails++; $display("FAIL clamp_done got none exp pulse"); end
        @(negedge clk);
        asserts++;
        if (got_dout.size() !== 4) begin
            fails++; $display("FAIL clamp_count got %0d exp 4", got_dout.size());
        end else begin
            for (int x = 0; x < 4; x++) begin
                asserts++;
                if (got_dout[x] !== want[x]) begin
                    fails++;
                    $display("FAIL clamp_dout%0d got %0d exp %0d",
                             x, got_dout[x], want[x]);
                end
            end
        end
    endtask

    task automatic test_step_zero();
        bit ok;
        fill_pix();
        clear_stats();
        push_model(5, 3, 0);
        do_start(5, 3, 1, 0);
        wait_pulse(1, 100, ok);
        @(negedge clk);
        asserts++;
        if (!ok || n_valid !== 3) begin
            fails++;
            $display("FAIL step0 got done %0b count %0d exp 1 3", ok, n_valid);
        end
    endtask

    task automatic test_multiline();
        bit ok;
        int bad_rd = 0;
        int bad_busy = 0;
        fill_pix();
        clear_stats();
        for (int l = 0; l < 3; l++) push_model(6, 4, 'h140);
        line_rdy = 1'b1;
        do_start(6, 4, 3, 'h140);
        for (int l = 0; l < 3; l++) begin
            wait_pulse(0, 200, ok);
            asserts++;
            if (!ok) begin
                fails++; $display("FAIL multi_ld%0d got none exp pulse", l);
            end
            if (l < 2) begin
                line_rdy = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    if (rd_en) bad_rd++;
                    if (!busy) bad_busy++;
                end
                line_rdy = 1'b1;
            end
        end
        wait_pulse(1, 50, ok);
        @(negedge clk);
        @(negedge clk);
        asserts++;
        if (n_ld !== 3 || n_done !== 1) begin
            fails++;
            $display("FAIL multi_pulses got %0d/%0d exp 3/1", n_ld, n_done);
        end
        asserts++;
        if (bad_rd !== 0 || bad_busy !== 0) begin
            fails++;
            $display("FAIL multi_wait got rd %0d idle %0d exp 0 0",
                     bad_rd, bad_busy);
        end
        asserts++;
        if (busy !== 1'b0 || n_valid !== 12) begin
            fails++;
            $display("FAIL multi_end got busy %0b valid %0d exp 0 12",
                     busy, n_valid);
        end
    endtask

    task automatic test_cfg_err();
        bit ok;
        do_start(1, 4, 1, 'h100);
        asserts++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL cfg_bad got err %0b busy %0b exp 1 0", cfg_err, busy);
        end
        fill_pix();
        clear_stats();
        push_model(5, 5, 'hC0);
        do_start(5, 5, 1, 'hC0);
        asserts++;
        if (cfg_err !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL cfg_good got err %0b busy %0b exp 0 1", cfg_err, busy);
        end
        wait_pulse(1, 100, ok);
        @(negedge clk);
        asserts++;
        if (!ok || n_valid !== 5) begin
            fails++;
            $display("FAIL cfg_run got done %0b count %0d exp 1 5", ok, n_valid);
        end
    endtask

    task automatic test_abort();
        int seen = 0;
        int bad = 0;
        bit ok;
        fill_pix();
        clear_stats();
        push_model(4, 7, 'h80);
        do_start(4, 7, 1, 'h80);
        for (int c = 0; c < 50 && seen < 2; c++) begin
            @(negedge clk);
            if (rd_en) seen++;
        end
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid || line_done || done || busy || rd_en) bad++;
        end
        asserts++;
        if (n_rd !== 3) begin
            fails++; $display("FAIL abort_reads got %0d exp 3", n_rd);
        end
        asserts++;
        if (bad !== 0) begin
            fails++; $display("FAIL abort_quiet got %0d active exp 0", bad);
        end
        clear_stats();
        push_model(4, 7, 'h80);
        do_start(4, 7, 1, 'h80);
        wait_pulse(1, 100, ok);
        @(negedge clk);
        asserts++;
        if (!ok || n_valid !== 7) begin
            fails++;
            $display("FAIL abort_rerun got done %0b count %0d exp 1 7",
                     ok, n_valid);
        end
    endtask

    task automatic test_rst_drain();
        int seen = 0;
        bit ok;
        fill_pix();
        clear_stats();
        push_model(4, 7, 'h80);
        do_start(4, 7, 1, 'h80);
        for (int c = 0; c < 50 && seen < 7; c++) begin
            @(negedge clk);
            if (rd_en) seen++;
        end
        @(negedge clk);
        asserts++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL drain_pre got valid %0b busy %0b exp 1 1",
                     out_valid, busy);
        end
        rst = 1'b0;
        #1;
        asserts++;
        if ({out_valid, out_last, busy, rd_en, kremain} !== '0) begin
            fails++;
            $display("FAIL drain_rst got %0b%0b%0b%0b k %0d exp 0",
                     out_valid, out_last, busy, rd_en, kremain);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_stats();
        push_model(4, 7, 'h80);
        do_start(4, 7, 1, 'h80);
        wait_pulse(1, 100, ok);
        @(negedge clk);
        asserts++;
        if (!ok || n_valid !== 7 || n_ld !== 1) begin
            fails++;
            $display("FAIL rst_rerun got done %0b count %0d ld %0d exp 1 7 1",
                     ok, n_valid, n_ld);
        end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_upscale();
        test_downscale();
        test_clamp();
        test_step_zero();
        test_multiline();
        test_cfg_err();
        test_abort();
        test_rst_drain();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end
endmodule
